// File: rtl/program_loader.sv
// program_loader: boot-time loader that streams a length-prefixed image into instruction memory
// and holds the CPU stalled until the image is complete. Optional checksum via LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int IM_ADDR_W_m1 = 7,
  parameter int IM_DATA_W_m1 = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  input  logic                    reload,
  output logic                    im_we,
  output logic [IM_ADDR_W_m1:0]   im_addr,
  output logic [IM_DATA_W_m1:0]   im_wdata,
  output logic                    cpu_run,
  output logic                    busy,
  output logic                    error,
  output logic [2:0]              dbg_state
);

  localparam int AW = IM_ADDR_W_m1 + 1;
  localparam int DW = IM_DATA_W_m1 + 1;
  localparam int CW = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [31:0]   DEPTH_32 = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_LOAD = 3'd1,
`ifdef LOADER_CHECKSUM_EN
    S_CHK  = 3'd2,
`endif
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_addr;
  logic [CW-1:0]   r_left;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic            r_cpu_run;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      r_sum;
`endif

  logic            w_accept;
  logic            w_last;
  logic            w_len_bad;
  logic [31:0]     w_len_ext;
  logic [CW-1:0]   w_len_n;

  // Handshake: a byte transfers on a rising edge where in_valid & in_ready are both high.
  // in_ready is a function of state (and rst) only, never of in_valid.
`ifdef LOADER_CHECKSUM_EN
  assign in_ready = ~rst & ((r_state == S_LEN) | (r_state == S_LOAD) | (r_state == S_CHK));
  assign busy     = (r_state == S_LOAD) | (r_state == S_CHK);
`else
  assign in_ready = ~rst & ((r_state == S_LEN) | (r_state == S_LOAD));
  assign busy     = (r_state == S_LOAD);
`endif
  assign error     = (r_state == S_ERR);
  assign cpu_run   = r_cpu_run;
  assign im_we     = r_we;
  assign im_addr   = r_waddr;
  assign im_wdata  = r_wdata;
  assign dbg_state = r_state;

  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_left == CW'(1));
  assign w_len_ext = {24'd0, in_data};
  // A length byte of zero stands for a full-depth image.
  assign w_len_bad = (w_len_ext > DEPTH_32);
  assign w_len_n   = (in_data == 8'd0) ? DEPTH_C : w_len_ext[CW-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN: begin
        if (w_accept) w_next = w_len_bad ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        if (w_accept && w_last) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_RUN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) w_next = (in_data == r_sum) ? S_RUN : S_ERR;
      end
`endif
      S_RUN: begin
        if (reload) w_next = S_LEN;
      end
      S_ERR: begin
        if (reload) w_next = S_LEN;
      end
      default: w_next = S_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LEN;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_left    <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_cpu_run <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if ((r_state == S_LEN) && w_accept) begin
        r_addr <= '0;
        r_left <= w_len_n;
`ifdef LOADER_CHECKSUM_EN
        r_sum  <= '0;
`endif
      end
      if ((r_state == S_LOAD) && w_accept) begin
        r_we    <= 1'b1;
        r_waddr <= r_addr;
        r_wdata <= DW'(in_data);
        r_addr  <= r_addr + AW'(1);
        r_left  <= r_left - CW'(1);
`ifdef LOADER_CHECKSUM_EN
        r_sum   <= r_sum + in_data;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      // The last data write has already landed when the check byte is accepted.
      r_cpu_run <= (w_next == S_RUN);
`else
      // Wait one cycle in RUN so the final registered write lands before the first fetch.
      r_cpu_run <= (r_state == S_RUN) && (w_next == S_RUN);
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: spec-level model + scoreboard, directed and random loads.
module tb_program_loader;

  localparam int DEPTH = 256;
  localparam int PH_LEN = 0, PH_LOAD = 1, PH_CHK = 2, PH_RUN = 3, PH_ERR = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       reload = 1'b0;
  logic       in_ready, im_we, cpu_run, busy, error;
  logic [7:0] im_addr, im_wdata;
  logic [2:0] dbg_state;

  logic       s_rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_reload = 1'b0;
  logic       s_ready, s_we, s_run, s_busy, s_err;
  logic [3:0] s_addr;
  logic [7:0] s_wdata;
  logic [2:0] s_dbg;

  program_loader #(.IM_ADDR_W_m1(7), .IM_DATA_W_m1(7)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_run(cpu_run), .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  program_loader #(.IM_ADDR_W_m1(3), .IM_DATA_W_m1(7)) u_small (
    .clk(clk), .rst(s_rst), .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready),
    .reload(s_reload), .im_we(s_we), .im_addr(s_addr), .im_wdata(s_wdata),
    .cpu_run(s_run), .busy(s_busy), .error(s_err), .dbg_state(s_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  int         ph = PH_LEN;
  int         m_left = 0, m_next = 0, m_sum = 0;
  bit         m_we = 0, m_run = 0, m_run_pend = 0, m_live = 0;
  int         m_waddr = 0, m_wdata = 0;
  logic [15:0] exp_q[$];
  logic [7:0] mem[DEPTH];
  logic [7:0] exp_mem[DEPTH];
  logic [7:0] img[DEPTH];

  always @(posedge clk) begin : model
    bit acc;
    cyc++;
    m_we = 0;
    if (rst) begin
      ph = PH_LEN; m_waddr = 0; m_wdata = 0; m_run = 0; m_run_pend = 0; m_live = 1;
    end else if (m_live) begin
      if (m_run_pend) begin m_run = 1; m_run_pend = 0; end
      acc = in_valid && (ph == PH_LEN || ph == PH_LOAD || ph == PH_CHK);
      case (ph)
        PH_LEN: if (acc) begin
          m_left = (in_data == 8'd0) ? DEPTH : int'(in_data);
          if (m_left > DEPTH) ph = PH_ERR;
          else begin ph = PH_LOAD; m_next = 0; m_sum = 0; end
        end
        PH_LOAD: if (acc) begin
          m_we = 1; m_waddr = m_next; m_wdata = int'(in_data);
          m_next = (m_next + 1) % DEPTH;
          m_sum = (m_sum + int'(in_data)) % 256;
          m_left--;
          if (m_left == 0) begin
            if (CHK_EN) ph = PH_CHK;
            else begin ph = PH_RUN; m_run_pend = 1; end
          end
        end
        PH_CHK: if (acc) begin
          if (int'(in_data) == m_sum) begin ph = PH_RUN; m_run = 1; end
          else ph = PH_ERR;
        end
        PH_RUN: if (reload) begin ph = PH_LEN; m_run = 0; m_run_pend = 0; end
        default: if (reload) ph = PH_LEN;
      endcase
    end
  end

  // ---------------- compare process + scoreboard ----------------
  int          wr_cyc[$];
  logic [15:0] wr_ad[$];
  int          run_rise_cyc = -1;
  bit          prev_run = 0;

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", in_ready, (!rst && (ph == PH_LEN || ph == PH_LOAD || ph == PH_CHK)));
      chk("busy", busy, (ph == PH_LOAD || ph == PH_CHK));
      chk("error", error, (ph == PH_ERR));
      chk("cpu_run", cpu_run, m_run);
      chk("im_we", im_we, m_we);
      if (im_we && m_we) begin
        chk("im_addr", im_addr, m_waddr);
        chk("im_wdata", im_wdata, m_wdata);
      end
      if (im_we) begin
        mem[im_addr] = im_wdata;
        wr_cyc.push_back(cyc);
        wr_ad.push_back({im_addr, im_wdata});
        chk("sb_pending", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("sb_write", {im_addr, im_wdata}, exp_q.pop_front());
      end
      if (cpu_run && !prev_run) run_rise_cyc = cyc;
      prev_run = cpu_run;
    end
  end

  int         s_wr_cnt = 0;
  int         s_last_addr = -1;
  int         s_wsum = 0;
  always @(negedge clk) begin
    if (s_we) begin
      s_wr_cnt++;
      s_last_addr = int'(s_addr);
      s_wsum = s_wsum + int'(s_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int k = 0; k < n; k++) begin
      reload = rr && ($urandom_range(0, 3) == 0);
      sync();
    end
    reload = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 0;
    in_valid = 1'b1; in_data = b;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk); acc = in_ready;
      sync();
    end
    in_valid = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic pulse_reload();
    reload = 1'b1; sync(); reload = 1'b0;
  endtask

  // mode 0: full rate, 1: valid every other cycle, 2: random gaps with ignored reload pulses
  task automatic load_image(input int lb, input int n, input int mode);
    int s = 0;
    if (mode == 2) idle($urandom_range(0, 2), 1'b1);
    send_byte(lb[7:0]);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({i[7:0], img[i]});
      exp_mem[i] = img[i];
      s = s + int'(img[i]);
      if (mode == 1) idle(1, 1'b0);
      else if (mode == 2) idle($urandom_range(0, 2), 1'b1);
      send_byte(img[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(s[7:0]);
`endif
  endtask

  task automatic wait_run(input int bound);
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (cpu_run) break;
    end
    chk("wait_cpu_run", cpu_run, 1);
    sync();
  endtask

  task automatic check_image(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk("image_words_bad", bad, 0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic s_send(input logic [7:0] b);
    bit acc = 0;
    s_valid = 1'b1; s_data = b;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk); acc = s_ready;
      sync();
    end
    s_valid = 1'b0;
    chk("s_send_accept", acc, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, n, sgap;
    // Reset and pinned reset values.
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_im_we", im_we, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_in_ready", in_ready, 0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    sync();

    // 03,A1,B2,C3 at full rate.
    img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3;
    base = wr_ad.size();
    load_image(3, 3, 0);
    wait_run(20);
    chk("w0", wr_ad[base], 16'h00A1);
    chk("w1", wr_ad[base+1], 16'h01B2);
    chk("w2", wr_ad[base+2], 16'h02C3);
    chk("w_consecutive", (wr_cyc[base+2] - wr_cyc[base]), 2);
    chk("run_after_last_write", run_rise_cyc, wr_cyc[base+2] + 1);
    check_image(3);

    // Reload from RUN: cpu_run drops on the same edge, loader ready again.
    pulse_reload();
    @(negedge clk);
    chk("reload_cpu_run", cpu_run, 0);
    chk("reload_ready", in_ready, 1);
    sync();

    // in_valid toggling every other cycle, overwrite from address 0.
    for (int i = 0; i < 6; i++) img[i] = 8'($urandom_range(0, 255));
    base = wr_ad.size();
    load_image(6, 6, 1);
    wait_run(40);
    sgap = 0;
    for (int k = 1; k < 6; k++) if (wr_cyc[base+k] - wr_cyc[base+k-1] != 2) sgap++;
    chk("toggle_spacing_bad", sgap, 0);
    chk("toggle_first_addr", wr_ad[base][15:8], 0);
    check_image(6);

`ifdef LOADER_CHECKSUM_EN
    pulse_reload();
    img[0] = 8'h10; img[1] = 8'h20;
    load_image(2, 2, 0);
    wait_run(20);
    chk("chk_good_run", cpu_run, 1);
    pulse_reload();
    exp_q.push_back(16'h0010); exp_q.push_back(16'h0120);
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
    @(negedge clk);
    chk("chk_bad_error", error, 1);
    chk("chk_bad_cpu_run", cpu_run, 0);
    sync();
`endif

    // Full-depth image via L=00.
    pulse_reload();
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom_range(0, 255));
    base = wr_ad.size();
    load_image(0, DEPTH, 0);
    wait_run(40);
    chk("full_write_count", wr_ad.size() - base, DEPTH);
    chk("full_last_addr", wr_ad[base+DEPTH-1][15:8], 8'hFF);
    check_image(DEPTH);

    // Reset after the 2nd of 5 data bytes.
    pulse_reload();
    send_byte(8'd5);
    for (int i = 0; i < 2; i++) begin
      img[i] = 8'($urandom_range(0, 255));
      exp_q.push_back({i[7:0], img[i]});
      exp_mem[i] = img[i];
      send_byte(img[i]);
    end
    rst = 1'b1;
    sync();
    @(negedge clk);
    chk("abort_im_we", im_we, 0);
    chk("abort_busy", busy, 0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", in_ready, 1);
    chk("abort_sb_drained", exp_q.size(), 0);
    sync();
    for (int i = 0; i < 5; i++) img[i] = 8'($urandom_range(0, 255));
    load_image(5, 5, 0);
    wait_run(20);
    check_image(5);

    // Randomized loads with gaps and ignored reload pulses.
    for (int it = 0; it < 8; it++) begin
      pulse_reload();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) img[i] = 8'($urandom_range(0, 255));
      load_image(n, n, 2);
      wait_run(40);
      check_image(n);
    end

    // Depth-16 instance: oversize length errors out, L=00 loads exactly 16 words.
    sync();
    s_rst = 1'b0;
    sync();
    s_send(8'h20);
    @(negedge clk);
    chk("s_err_oversize", s_err, 1);
    chk("s_run_oversize", s_run, 0);
    chk("s_ready_err", s_ready, 0);
    chk("s_no_writes", s_wr_cnt, 0);
    sync();
    s_reload = 1'b1; sync(); s_reload = 1'b0;
    @(negedge clk);
    chk("s_ready_after_reload", s_ready, 1);
    chk("s_err_cleared", s_err, 0);
    sync();
    s_send(8'h00);
    for (int i = 0; i < 16; i++) s_send(8'(i + 1));
`ifdef LOADER_CHECKSUM_EN
    s_send(8'h88);
`endif
    for (int t = 0; t < 20 && !s_run; t++) sync();
    @(negedge clk);
    chk("s_run", s_run, 1);
    chk("s_write_count", s_wr_cnt, 16);
    chk("s_last_addr", s_last_addr, 15);
    chk("s_data_sum", s_wsum, 136);
    sync();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
